bf_radix2_pipe: RTL

BF_RADIX2_PIPE -- requirements
Module: bf_radix2_pipe

---
 rtl/fft_pkg.sv | 47 ++++
 rtl/bf_cmul.sv | 68 ++++++
 rtl/bf_radix2_pipe.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT datapath stages.
//   FFT_DATA_W : default width of every data and twiddle component (two's compl.)
//   FFT_FRAC_W : default fractional bits, Q(DATA_W-FRAC_W-1).FRAC_W
//   round_sat  : round-half-up by a right shift of 'sh' bits, then clamp to a
//                signed 'out_w'-bit range. Caller narrows with a size cast.
//   round_ovf  : 1 when round_sat would clamp for the same arguments.
// Intermediate values are carried in 64 bits, which covers DATA_W up to 30.
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_DATA_W = 16;
    localparam int FFT_FRAC_W = 8;

    function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                       input int                 sh);
        if (sh <= 0)
            return v;
        return (v + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

    function automatic logic signed [63:0] round_sat(input logic signed [63:0] v,
                                                     input int                 sh,
                                                     input int                 out_w);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = round_shift(v, sh);
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (r > hi)
            r = hi;
        else if (r < lo)
            r = lo;
        return r;
    endfunction

    function automatic logic round_ovf(input logic signed [63:0] v,
                                       input int                 sh,
                                       input int                 out_w);
        logic signed [63:0] r;
        r = round_shift(v, sh);
        return (r > ((64'sd1 <<< (out_w - 1)) - 64'sd1)) || (r < -(64'sd1 <<< (out_w - 1)));
    endfunction

endpackage

// File: rtl/bf_cmul.sv
// -----------------------------------------------------------------------------
// bf_cmul
// Stages 2-3 of the radix-2 butterfly: Y1 = X * W with a single rounding.
// Stage 2 registers the four exact partial products; stage 3 (combinational
// here, registered by the parent) forms Pre/Pim at full width, rounds and
// saturates.
//   clk        : clock
//   en         : pipeline advance; product registers hold when low
//   x_re, x_im : A-B from stage 1, DATA_W+1 bits signed
//   w_re, w_im : twiddle aligned with X, DATA_W bits signed
//   scale      : stage-2 scale flag (extra halving of the result)
//   y_re, y_im : rounded and saturated product, DATA_W bits signed
//   ovf        : (only with BF_OVF_FLAG_EN) either component clipped
// -----------------------------------------------------------------------------
module bf_cmul
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int FRAC_W = FFT_FRAC_W
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic signed [DATA_W:0]   x_re,
    input  logic signed [DATA_W:0]   x_im,
    input  logic signed [DATA_W-1:0] w_re,
    input  logic signed [DATA_W-1:0] w_im,
    input  logic                     scale,
    output logic signed [DATA_W-1:0] y_re,
    output logic signed [DATA_W-1:0] y_im
`ifdef BF_OVF_FLAG_EN
    ,
    output logic                     ovf
`endif
);

    localparam int PW = 2 * DATA_W + 1;

    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [63:0]   p_re, p_im;
    int                   sh;

    // NOTE: datapath registers carry no reset; only the valid bits need a
    // known state, and leaving data unreset keeps reset fan-out off the wide buses.
    always_ff @(posedge clk) begin
        if (en) begin
            p_rr <= PW'(x_re) * PW'(w_re);
            p_ii <= PW'(x_im) * PW'(w_im);
            p_ri <= PW'(x_re) * PW'(w_im);
            p_ir <= PW'(x_im) * PW'(w_re);
        end
    end

    // NOTE: every signal written in always_comb gets a value on every path,
    // otherwise a latch is inferred.
    always_comb begin
        p_re = 64'(p_rr) - 64'(p_ii);
        p_im = 64'(p_ri) + 64'(p_ir);
        sh   = scale ? FRAC_W + 1 : FRAC_W;
    end

    assign y_re = DATA_W'(round_sat(p_re, sh, DATA_W));
    assign y_im = DATA_W'(round_sat(p_im, sh, DATA_W));

`ifdef BF_OVF_FLAG_EN
    assign ovf = round_ovf(p_re, sh, DATA_W) | round_ovf(p_im, sh, DATA_W);
`endif

endmodule

// File: rtl/bf_radix2_pipe.sv
// -----------------------------------------------------------------------------
// bf_radix2_pipe
// Three-stage pipelined radix-2 DIF butterfly with valid/ready handshake.
//   Y0 = A + B                (optionally halved, round half up)
//   Y1 = (A - B) * W          (rounded once, optionally halved)
// All results saturate. A single global advance stalls every stage, bubbles
// included, whenever a held result is not taken downstream.
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   in_valid / in_ready            : input handshake (in_ready = advance)
//   in_scale                       : per-beat halving of both outputs
//   a_re, a_im, b_re, b_im         : operands
//   w_re, w_im                     : twiddle
//   out_valid / out_ready          : output handshake
//   y0_re, y0_im, y1_re, y1_im     : results, undefined while out_valid is 0
//   out_ovf                        : only with macro BF_OVF_FLAG_EN;
//                                    bit0 = Y0 clipped, bit1 = Y1 clipped
// -----------------------------------------------------------------------------
module bf_radix2_pipe
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int FRAC_W = FFT_FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_scale,
    input  logic [DATA_W-1:0] a_re,
    input  logic [DATA_W-1:0] a_im,
    input  logic [DATA_W-1:0] b_re,
    input  logic [DATA_W-1:0] b_im,
    input  logic [DATA_W-1:0] w_re,
    input  logic [DATA_W-1:0] w_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y0_re,
    output logic [DATA_W-1:0] y0_im,
    output logic [DATA_W-1:0] y1_re,
    output logic [DATA_W-1:0] y1_im
`ifdef BF_OVF_FLAG_EN
    ,
    output logic [1:0]        out_ovf
`endif
);

    logic advance;

    logic                     s1_valid, s2_valid;
    logic signed [DATA_W:0]   s1_sum_re, s1_sum_im, s1_dif_re, s1_dif_im;
    logic signed [DATA_W-1:0] s1_w_re, s1_w_im;
    logic                     s1_scale;
    logic signed [DATA_W:0]   s2_sum_re, s2_sum_im;
    logic                     s2_scale;

    int                       y0_sh;
    logic signed [DATA_W-1:0] y0_re_n, y0_im_n, y1_re_n, y1_im_n;

    // A held result freezes the whole pipe; an empty output slot always drains.
    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
        end
    end

    // Stage 1: exact sum and difference at DATA_W+1 bits; twiddle travels along.
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_sum_re <= {a_re[DATA_W-1], a_re} + {b_re[DATA_W-1], b_re};
            s1_sum_im <= {a_im[DATA_W-1], a_im} + {b_im[DATA_W-1], b_im};
            s1_dif_re <= {a_re[DATA_W-1], a_re} - {b_re[DATA_W-1], b_re};
            s1_dif_im <= {a_im[DATA_W-1], a_im} - {b_im[DATA_W-1], b_im};
            s1_w_re   <= w_re;
            s1_w_im   <= w_im;
            s1_scale  <= in_scale;
        end
    end

    // Stage 2: Y0 path delay-matched to the product registers inside bf_cmul.
    always_ff @(posedge clk) begin
        if (advance) begin
            s2_sum_re <= s1_sum_re;
            s2_sum_im <= s1_sum_im;
            s2_scale  <= s1_scale;
        end
    end

`ifdef BF_OVF_FLAG_EN
    logic y1_ovf;
`endif

    bf_cmul #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_cmul (
        .clk   (clk),
        .en    (advance),
        .x_re  (s1_dif_re),
        .x_im  (s1_dif_im),
        .w_re  (s1_w_re),
        .w_im  (s1_w_im),
        .scale (s2_scale),
        .y_re  (y1_re_n),
        .y_im  (y1_im_n)
`ifdef BF_OVF_FLAG_EN
        ,
        .ovf   (y1_ovf)
`endif
    );

    // Y0 halving with a shift of 1 and round-half-up gives (A+B+1)>>>1.
    assign y0_sh   = s2_scale ? 1 : 0;
    assign y0_re_n = DATA_W'(round_sat(64'(s2_sum_re), y0_sh, DATA_W));
    assign y0_im_n = DATA_W'(round_sat(64'(s2_sum_im), y0_sh, DATA_W));

    // Stage 3: output registers; holding them while stalled keeps data stable.
    always_ff @(posedge clk) begin
        if (advance) begin
            y0_re <= y0_re_n;
            y0_im <= y0_im_n;
            y1_re <= y1_re_n;
            y1_im <= y1_im_n;
        end
    end

`ifdef BF_OVF_FLAG_EN
    logic y0_ovf;
    assign y0_ovf = round_ovf(64'(s2_sum_re), y0_sh, DATA_W)
                  | round_ovf(64'(s2_sum_im), y0_sh, DATA_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_ovf <= 2'b00;
        else if (advance)
            out_ovf <= {y1_ovf, y0_ovf};
    end
`endif

endmodule
